gpc_pipe: RTL and testbench

Parametrised, pipelined generalized parallel counter for the compressor-tree library. It sums three input columns of weights 1, 2 and 4, each of configurable height, into a binary count, with a `valid`/`ready` handshake on both sides. It also carries an optional running accumulator for multi-beat popcount/reduction. It sits between operand staging and the final carry-propagate adder. It is the registered, streaming generalisation of the fixed combinational 6;2;3 counter.

---
 rtl/gpc_pipe.sv | 126 ++++++++++++
 tb/tb_gpc_pipe.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gpc_pipe.sv
// Two-stage streaming generalized parallel counter: column popcounts, then
// weighted sum, with valid/ready on both sides and an optional running accumulator.
module gpc_pipe #(
  parameter int H0   = 3,
  parameter int H1   = 2,
  parameter int H2   = 6,
  parameter int OW   = 5,
  parameter int ACCW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [H0-1:0]   src0,
  input  logic [H1-1:0]   src1,
  input  logic [H2-1:0]   src2,
  input  logic            acc_en,
  input  logic            acc_clr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OW-1:0]   dst,
  output logic [ACCW-1:0] acc,
  output logic            acc_ovf
);

  localparam int C0W = $clog2(H0 + 1);
  localparam int C1W = $clog2(H1 + 1);
  localparam int C2W = $clog2(H2 + 1);

  logic             v1_q, v1_d, v2_q, v2_d;
  logic             t1_q, t1_d, t2_q, t2_d;
  logic [C0W-1:0]   c0_q, c0_d, pc0;
  logic [C1W-1:0]   c1_q, c1_d, pc1;
  logic [C2W-1:0]   c2_q, c2_d, pc2;
  logic [OW-1:0]    dst_q, dst_d;
  logic [ACCW-1:0]  acc_q, acc_d;
  logic             acc_ovf_q, acc_ovf_d;
  logic             in_hs, adv1, out_hs;
  logic [ACCW:0]    acc_sum;

  // Stage 1 always drains when stage 2 is free or being emptied, so a full
  // pipe can still take a beat in the same cycle out_ready rises.
  assign in_ready  = !v1_q || !v2_q || out_ready;
  assign in_hs     = in_valid && in_ready;
  assign adv1      = v1_q && (!v2_q || out_ready);
  assign out_hs    = v2_q && out_ready;
  assign out_valid = v2_q;
  assign dst       = dst_q;
  assign acc       = acc_q;
  assign acc_ovf   = acc_ovf_q;

  always_comb begin
    pc0 = '0;
    pc1 = '0;
    pc2 = '0;
    for (int unsigned i = 0; i < H0; i++) pc0 = pc0 + C0W'(src0[i]);
    for (int unsigned i = 0; i < H1; i++) pc1 = pc1 + C1W'(src1[i]);
    for (int unsigned i = 0; i < H2; i++) pc2 = pc2 + C2W'(src2[i]);
  end

  always_comb begin
    v1_d = v1_q;
    t1_d = t1_q;
    c0_d = c0_q;
    c1_d = c1_q;
    c2_d = c2_q;
    if (in_hs) begin
      v1_d = 1'b1;
      t1_d = acc_en;
      c0_d = pc0;
      c1_d = pc1;
      c2_d = pc2;
    end else if (adv1) begin
      v1_d = 1'b0;
    end

    v2_d  = v2_q;
    t2_d  = t2_q;
    dst_d = dst_q;
    if (adv1) begin
      v2_d  = 1'b1;
      t2_d  = t1_q;
      dst_d = OW'(c0_q) + (OW'(c1_q) << 1) + (OW'(c2_q) << 2);
    end else if (out_hs) begin
      v2_d = 1'b0;
    end

    acc_sum   = {1'b0, acc_q} + (ACCW+1)'(dst_q);
    acc_d     = acc_q;
    acc_ovf_d = acc_ovf_q;
    if (acc_clr) begin
      acc_d     = (out_hs && t2_q) ? ACCW'(dst_q) : '0;
      acc_ovf_d = 1'b0;
    end else if (out_hs && t2_q) begin
      acc_d     = acc_sum[ACCW-1:0];
      acc_ovf_d = acc_ovf_q | acc_sum[ACCW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      t1_q      <= 1'b0;
      t2_q      <= 1'b0;
      c0_q      <= '0;
      c1_q      <= '0;
      c2_q      <= '0;
      dst_q     <= '0;
      acc_q     <= '0;
      acc_ovf_q <= 1'b0;
    end else begin
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      t1_q      <= t1_d;
      t2_q      <= t2_d;
      c0_q      <= c0_d;
      c1_q      <= c1_d;
      c2_q      <= c2_d;
      dst_q     <= dst_d;
      acc_q     <= acc_d;
      acc_ovf_q <= acc_ovf_d;
    end
  end

endmodule

// File: tb/tb_gpc_pipe.sv
// Self-checking bench for gpc_pipe: a beat-level queue model (items in flight with
// their age) predicts handshakes, results and accumulators for two accumulator widths.
module tb_gpc_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, acc_en, acc_clr, out_ready;
  logic [2:0]  src0;
  logic [1:0]  src1;
  logic [5:0]  src2;
  logic        in_ready_a, out_valid_a, ovf_a;
  logic [4:0]  dst_a;
  logic [15:0] acc_a;
  logic        in_ready_b, out_valid_b, ovf_b;
  logic [4:0]  dst_b;
  logic [5:0]  acc_b;

  gpc_pipe dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .src0(src0), .src1(src1), .src2(src2), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(out_valid_a), .out_ready(out_ready), .dst(dst_a), .acc(acc_a),
    .acc_ovf(ovf_a)
  );

  gpc_pipe #(.ACCW(6)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .src0(src0), .src1(src1), .src2(src2), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(out_valid_b), .out_ready(out_ready), .dst(dst_b), .acc(acc_b),
    .acc_ovf(ovf_b)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int nfail = 0;
  int ntotal = 0;

  // Model state: beats in flight, oldest first; age = edges since acceptance.
  int          q_dst[$];
  bit          q_tag[$];
  int          q_age[$];
  int unsigned m_acc_a = 0, m_acc_b = 0;
  bit          m_ovf_a = 0, m_ovf_b = 0;
  bit          last_acc;
  bit          dut_took;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int beat_sum(input logic [2:0] a, input logic [1:0] b, input logic [5:0] c);
    return $countones(a) + 2 * $countones(b) + 4 * $countones(c);
  endfunction

  task automatic acc_model(inout int unsigned a, inout bit ovf, input int unsigned w,
                           input bit clr, input bit hs_tag, input int d);
    if (clr && hs_tag) begin
      a = d; ovf = 0;
    end else if (clr) begin
      a = 0; ovf = 0;
    end else if (hs_tag) begin
      a = a + d;
      if (a >= (32'd1 << w)) begin
        ovf = 1;
        a   = a - (32'd1 << w);
      end
    end
  endtask

  // One clock: check outputs against the model, take the edge, advance the model.
  task automatic tick();
    bit m_in_ready, m_out_valid, ohs, ihs, clr, tag;
    int d;
    #1;
    m_in_ready  = (q_dst.size() < 2) || out_ready;
    m_out_valid = (q_dst.size() > 0) && (q_age[0] >= 1);
    chk("in_ready", in_ready_a, m_in_ready);
    chk("out_valid", out_valid_a, m_out_valid);
    if (m_out_valid) chk("dst", dst_a, q_dst[0]);
    chk("acc16", acc_a, m_acc_a);
    chk("ovf16", ovf_a, m_ovf_a);
    chk("acc6", acc_b, m_acc_b);
    chk("ovf6", ovf_b, m_ovf_b);
    dut_took = in_ready_a && in_valid;
    ohs = m_out_valid && out_ready;
    ihs = in_valid && m_in_ready;
    clr = acc_clr;
    d   = ohs ? q_dst[0] : 0;
    tag = ohs ? q_tag[0] : 1'b0;
    @(posedge clk);
    acc_model(m_acc_a, m_ovf_a, 16, clr, ohs && tag, d);
    acc_model(m_acc_b, m_ovf_b, 6, clr, ohs && tag, d);
    if (ohs) begin
      void'(q_dst.pop_front());
      void'(q_tag.pop_front());
      void'(q_age.pop_front());
    end
    foreach (q_age[i]) q_age[i]++;
    if (ihs) begin
      q_dst.push_back(beat_sum(src0, src1, src2));
      q_tag.push_back(acc_en);
      q_age.push_back(0);
    end
    last_acc = ihs;
    #1;
  endtask

  task automatic send(input logic [2:0] a, input logic [1:0] b, input logic [5:0] c, input bit en);
    int k;
    in_valid = 1'b1; src0 = a; src1 = b; src2 = c; acc_en = en;
    k = 0;
    last_acc = 0;
    while (!last_acc && k < 50) begin
      tick();
      k++;
    end
    chk("send_accepted", last_acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic clear_acc();
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b1; in_valid = 0; acc_en = 0; acc_clr = 0; out_ready = 0;
    src0 = '0; src1 = '0; src2 = '0;
    #2;
    chk("rst_in_ready", in_ready_a, 1);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_dst", dst_a, 0);
    chk("rst_acc", acc_a, 0);
    chk("rst_ovf", ovf_a, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // Basic sum and latency
    send(3'd1, 2'd2, 6'h2d, 1'b0);
    chk("lat_edge_n", out_valid_a, 0);
    tick();
    chk("lat_edge_n1", out_valid_a, 1);
    chk("basic_13", dst_a, 5'h13);
    send(3'd7, 2'd3, 6'h3f, 1'b0);
    tick();
    chk("basic_1f", dst_a, 5'h1f);
    tick();
    tick();

    // Streaming: 20 random back-to-back beats
    cnt = 0;
    for (int i = 0; i < 22; i++) begin
      in_valid = (i < 20);
      src0 = 3'($urandom); src1 = 2'($urandom); src2 = 6'($urandom);
      acc_en = 1'($urandom);
      tick();
      if (out_valid_a) cnt++;
    end
    in_valid = 0;
    chk("stream_count", cnt, 20);
    clear_acc();

    // Back-pressure
    out_ready = 1'b0;
    send(3'd1, 2'd2, 6'h2d, 1'b0);
    send(3'd7, 2'd3, 6'h3f, 1'b0);
    in_valid = 1'b1;
    src0 = 3'($urandom); src1 = 2'($urandom); src2 = 6'($urandom); acc_en = 0;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (dut_took) cnt++;
    end
    chk("bp_extra_accepted", cnt, 0);
    chk("bp_dst_stable", dst_a, 5'h13);
    out_ready = 1'b1;
    tick();
    chk("bp_accept_on_release", dut_took, 1);
    chk("bp_second", dst_a, 5'h1f);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    // Accumulate
    send(3'd1, 2'd2, 6'h2d, 1'b1);
    send(3'd7, 2'd3, 6'h3f, 1'b0);
    send(3'd7, 2'd3, 6'h3f, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    chk("acc_32", acc_a, 16'h32);
    chk("acc6_32", acc_b, 6'h32);
    send(3'd1, 2'd2, 6'h2d, 1'b1);
    tick();
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    chk("acc_clr_hs", acc_a, 16'h13);
    chk("acc6_clr_hs", acc_b, 6'h13);

    // Overflow on the 6-bit accumulator
    clear_acc();
    for (int i = 0; i < 3; i++) send(3'd7, 2'd3, 6'h3f, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    chk("ovf6_acc", acc_b, 6'h1d);
    chk("ovf6_flag", ovf_b, 1);
    chk("ovf16_acc", acc_a, 16'h5d);
    chk("ovf16_flag", ovf_a, 0);
    clear_acc();
    chk("ovf6_clr_acc", acc_b, 0);
    chk("ovf6_clr_flag", ovf_b, 0);

    // Reset mid-flight
    send(3'd7, 2'd3, 6'h3f, 1'b1);
    tick();
    tick();
    out_ready = 1'b0;
    send(3'd1, 2'd2, 6'h2d, 1'b1);
    send(3'd7, 2'd3, 6'h3f, 1'b1);
    tick();
    chk("pre_rst_acc", acc_a, 16'h1f);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", out_valid_a, 0);
    chk("rst_mid_acc", acc_a, 0);
    chk("rst_mid_in_ready", in_ready_a, 1);
    q_dst.delete(); q_tag.delete(); q_age.delete();
    m_acc_a = 0; m_acc_b = 0; m_ovf_a = 0; m_ovf_b = 0;
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(3'd1, 2'd1, 6'h0, 1'b0);
    tick();
    chk("post_rst_dst", dst_a, 5'h3);
    tick();
    tick();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
